arb_onehot_mux: RTL
===================

// Module: arb_onehot_mux
//
// PURPOSE
// N-channel valid/ready arbiter with a registered one-hot AND-OR data mux; successor to the combinational one-hot mux.
// Picks one requesting channel per cycle (round-robin or fixed priority), forms its one-hot grant, muxes its data,
// and captures the result in a single output register stage. Used where several bus sources share one sink.
//
// PARAMETERS
// N_INPUTS    2   number of request channels (>=1)
// W_INPUT     32  data width per channel
// ROUND_ROBIN 1   1: rotating priority; 0: fixed priority, lowest index wins
//
// PORTS
// clk       in   1                 clock; all state on rising edge
// rst_n     in   1                 reset, asynchronous, active-low
// in_vld    in   N_INPUTS          per-channel request valid
// in_rdy    out  N_INPUTS          per-channel accept; at most one bit set per cycle
// in_data   in   N_INPUTS*W_INPUT  channel i at [i*W_INPUT +: W_INPUT]
// in_last   in   N_INPUTS          end-of-packet marker; present only with ARB_MUX_LOCK_EN
// out_vld   out  1                 output register holds valid beat
// out_rdy   in   1                 sink accepts beat
// out_data  out  W_INPUT           registered muxed data
// out_src   out  N_INPUTS          one-hot index of channel that supplied out_data
//
// BEHAVIOUR
// - Reset: out_vld=0, out_data=0, out_src=0, priority pointer = channel 0 highest, lock cleared. Async assert, sync release.
// - load_en = !out_vld || out_rdy. Output register loads iff load_en && |in_vld. No bubble under continuous backpressure release.
// - Grant: combinational one-hot vector from in_vld and priority mask; in_rdy = grant & {N{load_en}}. Exactly one in_rdy bit on transfer.
// - Data path: AND-OR one-hot mux of in_data by grant (no priority-encoded index, no dmux tree).
// - Latency: input handshake at edge k -> out_vld=1 with that data from edge k onward; 1 cycle.
// - Throughput: 1 beat/cycle when out_rdy held high.
// - Out side: while out_vld && !out_rdy, out_data/out_src held stable. If load_en && no request: out_vld->0, out_data/out_src hold old values.
// - Round-robin: on transfer from channel i, channel (i+1) mod N becomes highest priority; pointer unchanged on cycles without transfer.
//   Wrap: transfer from N-1 -> channel 0 highest. N_INPUTS=1: pointer is constant, grant = in_vld.
// - Fixed priority (ROUND_ROBIN=0): pointer unused; lowest set in_vld wins every cycle.
// - Grant may change between cycles with no transfer (new higher-priority request); no channel is accepted without in_rdy.
// - Upstream rule: in_vld must stay high and in_data stable until in_rdy; arbiter never relies on this for correctness.
// - Reset mid-operation: out_vld drops immediately, held beat discarded, pointer and lock return to reset state.
//
// CONFIGURATION
// ARB_MUX_LOCK_EN defined: in_last port exists. Accepting a beat from channel i with in_last[i]=0 locks grant to i;
//   other channels get no in_rdy, even if i drops in_vld, until a beat from i with in_last[i]=1 is accepted; then
//   normal arbitration resumes (RR pointer advances past i on that final beat only). Lock flop resets to unlocked.
// ARB_MUX_LOCK_EN undefined: no in_last port, no lock state; every beat arbitrated independently.
//
// TESTING
// - Reset: hold rst_n=0 with all in_vld=1 -> out_vld=0, out_data=0, out_src=0, in_rdy=0 (out_vld=0 but no load while reset).
// - N=4 RR, all in_vld=1, out_rdy=1, data=i*0x11 -> out_src sequence 0001,0010,0100,1000,0001; out_data 00,11,22,33,00.
// - Backpressure: out_vld=1, out_rdy=0 for 5 cycles -> in_rdy=0, out_data/out_src constant; out_rdy=1 -> next beat loads same edge.
// - ROUND_ROBIN=0, in_vld=4'b1010 continuously -> only channel 1 accepted; channel 3 starved, out_src=0010 every cycle.
// - Mid-stream reset: assert rst_n=0 while out_vld=1 -> out_vld=0 asynchronously; after release channel 0 is highest priority.
// - ARB_MUX_LOCK_EN: ch2 sends 3 beats in_last=0,0,1 while ch0 requests -> ch0 gets no in_rdy until ch2's last beat accepted.

Source files
------------

// File: rtl/arb_onehot_mux.sv
// N-channel valid/ready arbiter that drives a registered one-hot AND-OR data mux.
// Define ARB_MUX_LOCK_EN to add in_last and hold the grant on one channel until its packet ends.
module arb_onehot_mux_lane #(
    parameter int W_INPUT = 32
) (
    input  logic               i_gnt,
    input  logic [W_INPUT-1:0] i_data,
    output logic [W_INPUT-1:0] o_term
);
    assign o_term = i_data & {W_INPUT{i_gnt}};
endmodule

module arb_onehot_mux #(
    parameter int N_INPUTS    = 2,
    parameter int W_INPUT     = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_INPUTS-1:0]           in_vld,
    output logic [N_INPUTS-1:0]           in_rdy,
    input  logic [N_INPUTS*W_INPUT-1:0]   in_data,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N_INPUTS-1:0]           in_last,
`endif
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [W_INPUT-1:0]            out_data,
    output logic [N_INPUTS-1:0]           out_src
);
    localparam logic [N_INPUTS-1:0] ONE = N_INPUTS'(1);

    logic                              r_vld;
    logic [W_INPUT-1:0]                r_data;
    logic [N_INPUTS-1:0]               r_src;
    logic                              w_load_en;
    logic                              w_xfer;
    logic                              w_adv;
    logic [N_INPUTS-1:0]               w_req;
    logic [N_INPUTS-1:0]               w_gnt;
    logic [N_INPUTS-1:0][W_INPUT-1:0]  w_terms;
    logic [W_INPUT-1:0]                w_mux;

    // Reset gates the accept path so no channel sees in_rdy while held in reset.
    assign w_load_en = rst_n & (~r_vld | out_rdy);
    assign w_xfer    = w_load_en & (|w_gnt);
    assign in_rdy    = w_gnt & {N_INPUTS{w_load_en}};

`ifdef ARB_MUX_LOCK_EN
    logic                r_lock;
    logic [N_INPUTS-1:0] r_lock_oh;

    // While locked only the owning channel may be granted, even if it goes idle.
    assign w_req = r_lock ? (in_vld & r_lock_oh) : in_vld;
    assign w_adv = w_xfer & (|(w_gnt & in_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_oh <= '0;
        end else if (w_xfer) begin
            r_lock    <= ~|(w_gnt & in_last);
            r_lock_oh <= w_gnt;
        end
    end
`else
    assign w_req = in_vld;
    assign w_adv = w_xfer;
`endif

    generate
        if (ROUND_ROBIN != 0 && N_INPUTS > 1) begin : g_rr
            logic [N_INPUTS-1:0] r_prio;
            logic [N_INPUTS-1:0] w_req_hi;
            logic [N_INPUTS-1:0] w_gnt_hi;
            logic [N_INPUTS-1:0] w_gnt_lo;

            // r_prio is one-hot; ~(r_prio-1) masks in every channel at or above it.
            assign w_req_hi = w_req & ~(r_prio - ONE);
            assign w_gnt_hi = w_req_hi & (~w_req_hi + ONE);
            assign w_gnt_lo = w_req & (~w_req + ONE);
            assign w_gnt    = (|w_req_hi) ? w_gnt_hi : w_gnt_lo;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_prio <= ONE;
                else if (w_adv)
                    r_prio <= {w_gnt[N_INPUTS-2:0], w_gnt[N_INPUTS-1]};
            end
        end else begin : g_fixed
            assign w_gnt = w_req & (~w_req + ONE);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
            arb_onehot_mux_lane #(.W_INPUT(W_INPUT)) u_lane (
                .i_gnt  (w_gnt[gi]),
                .i_data (in_data[gi*W_INPUT +: W_INPUT]),
                .o_term (w_terms[gi])
            );
        end
    endgenerate

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < N_INPUTS; i++)
            w_mux = w_mux | w_terms[i];
    end

    // An empty load cycle clears valid but keeps the last beat's data/source visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_src  <= '0;
        end else if (w_load_en) begin
            r_vld <= |w_gnt;
            if (|w_gnt) begin
                r_data <= w_mux;
                r_src  <= w_gnt;
            end
        end
    end

    assign out_vld  = r_vld;
    assign out_data = r_data;
    assign out_src  = r_src;
endmodule
